// File: rtl/nds_async_fifo_wr_packer.sv
// nds_async_fifo_wr_packer: w_clk-domain packer ahead of the async FIFO.
// Packs RATIO narrow beats into one FIFO word {lane_cnt_m1, last, data}.
//
// Ports:
//   w_clk, w_reset_n          write clock, async active-low reset
//   in_valid/in_data/in_last  beat handshake input, in_ready output
//   fifo_full                 registered FIFO full (w_clk domain)
//   fifo_wr, fifo_wr_data     FIFO push strobe and word
//   busy                      partial word pending or output stage occupied
//
// Build option: define NDS_ASYNC_FIFO_PACKER_TIMEOUT_EN to auto-flush a
// partial word after FLUSH_TIMEOUT idle cycles.
module nds_async_fifo_wr_packer #(
    parameter  int IN_WIDTH      = 8,
    parameter  int RATIO         = 4,
    parameter  int FLUSH_TIMEOUT = 16,
    localparam int CNT_W         = $clog2(RATIO),
    localparam int OUT_WIDTH     = IN_WIDTH * RATIO + 1 + CNT_W
) (
    input  logic                 w_clk,
    input  logic                 w_reset_n,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [OUT_WIDTH-1:0] fifo_wr_data,
    output logic                 busy
);

    localparam int DW     = IN_WIDTH * RATIO;
    localparam int IDLE_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(RATIO - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(FLUSH_TIMEOUT - 1);

    logic [DW-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic                 out_vld_q, out_vld_d;
    logic [OUT_WIDTH-1:0] out_reg_q, out_reg_d;

    logic          slot_free;
    logic          accept;
    logic          push;
    logic          complete;
    logic [DW-1:0] merged;

    // fifo_full is a register, so in_ready has no combinational loop.
    assign slot_free    = ~out_vld_q | ~fifo_full;
    assign in_ready     = slot_free;
    assign accept       = in_valid & slot_free;
    assign push         = out_vld_q & ~fifo_full;
    assign complete     = accept & ((idx_q == LAST_IDX) | in_last);
    assign fifo_wr      = push;
    assign fifo_wr_data = out_reg_q;
    assign busy         = (idx_q != '0) | out_vld_q;

    // Lanes above idx are still zero in acc, so merged carries zero padding.
    always_comb begin
        merged = acc_q;
        for (int i = 0; i < RATIO; i++) begin
            if (idx_q == CNT_W'(i)) begin
                merged[i*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

`ifdef NDS_ASYNC_FIFO_PACKER_TIMEOUT_EN
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              flush;

    // An accepted beat always wins over the timeout.
    assign flush = ~accept & (idx_q != '0) & (idle_q == IDLE_MAX) & slot_free;

    always_comb begin
        idle_d = idle_q;
        if (accept || flush) begin
            idle_d = '0;
        end else if ((idx_q != '0) && (idle_q != IDLE_MAX)) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge w_clk or negedge w_reset_n) begin
        if (!w_reset_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic flush;
    logic unused_cfg;

    assign flush      = 1'b0;
    assign unused_cfg = ^IDLE_MAX;
`endif

    always_comb begin
        acc_d     = acc_q;
        idx_d     = idx_q;
        out_vld_d = out_vld_q;
        out_reg_d = out_reg_q;

        if (push) begin
            out_vld_d = 1'b0;
        end

        // A load in the same cycle as a push keeps the stage full (back-to-back).
        if (complete) begin
            out_reg_d = {idx_q, in_last, merged};
            out_vld_d = 1'b1;
            acc_d     = '0;
            idx_d     = '0;
        end else if (accept) begin
            acc_d = merged;
            idx_d = idx_q + CNT_W'(1);
        end else if (flush) begin
            out_reg_d = {idx_q - CNT_W'(1), 1'b0, acc_q};
            out_vld_d = 1'b1;
            acc_d     = '0;
            idx_d     = '0;
        end
    end

    always_ff @(posedge w_clk or negedge w_reset_n) begin
        if (!w_reset_n) begin
            acc_q     <= '0;
            idx_q     <= '0;
            out_vld_q <= 1'b0;
            out_reg_q <= '0;
        end else begin
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            out_vld_q <= out_vld_d;
            out_reg_q <= out_reg_d;
        end
    end

endmodule

// File: tb/tb_nds_async_fifo_wr_packer.sv
// tb_nds_async_fifo_wr_packer: directed plus random bench for the packer.
// Expected words come from a beat-level model feeding a scoreboard queue.
module tb_nds_async_fifo_wr_packer;

    logic        w_clk = 1'b0;
    logic        w_reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        fifo_full;
    logic        fifo_wr;
    logic [34:0] fifo_wr_data;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [34:0] sb_q[$];
    logic [31:0] m_acc = '0;
    int          m_idx = 0;
    int          m_idle = 0;

    nds_async_fifo_wr_packer dut (
        .w_clk        (w_clk),
        .w_reset_n    (w_reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .fifo_full    (fifo_full),
        .fifo_wr      (fifo_wr),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy)
    );

    always #5 w_clk = ~w_clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [34:0] word(input int cnt, input logic last,
                                         input logic [31:0] d);
        return {2'(cnt), last, d};
    endfunction

    // Model and scoreboard, sampled on the falling edge.
    always @(negedge w_clk) begin
        if (w_reset_n) begin
            if (!fifo_full) chk("in_ready_not_full", in_ready, 1);
            if (fifo_wr) begin
                chk("no_push_while_full", fifo_full, 0);
                chk("sb_nonempty", 64'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) chk("push_word", fifo_wr_data, sb_q.pop_front());
            end
            if (in_valid && in_ready) begin
                m_acc[m_idx*8 +: 8] = in_data;
                m_idle = 0;
                if (m_idx == 3 || in_last) begin
                    sb_q.push_back(word(m_idx, in_last, m_acc));
                    m_acc = '0;
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
`ifdef NDS_ASYNC_FIFO_PACKER_TIMEOUT_EN
            else if (m_idx != 0) begin
                if (m_idle == 15 && in_ready) begin
                    sb_q.push_back(word(m_idx - 1, 1'b0, m_acc));
                    m_acc = '0;
                    m_idx = 0;
                    m_idle = 0;
                end else if (m_idle < 15) begin
                    m_idle++;
                end
            end
`endif
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        logic a;
        int   n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        a = 1'b0;
        while (!a && n < 200) begin
            @(negedge w_clk);
            a = in_ready;
            @(posedge w_clk);
            #1;
            n++;
        end
        if (!a) chk("send_accept_timeout", a, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    initial begin
        logic [34:0] held;
        logic        a;
        int          k;

        w_reset_n = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        fifo_full = 1'b0;
        #3;
        chk("rst_fifo_wr", fifo_wr, 0);
        chk("rst_data", fifo_wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        #9 w_reset_n = 1'b1;
        tick();

        // 1: two full words back-to-back
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        chk("t1_wr0", fifo_wr, 1);
        chk("t1_word0", fifo_wr_data, word(3, 0, 32'h44332211));
        send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
        chk("t1_wr1", fifo_wr, 1);
        chk("t1_word1", fifo_wr_data, word(3, 0, 32'h88776655));

        // 2: short packet closed by in_last
        send(8'hA1, 0); send(8'hA2, 1);
        chk("t2_wr", fifo_wr, 1);
        chk("t2_word", fifo_wr_data, word(1, 1, 32'h0000A2A1));
        tick();
        chk("t2_busy_drop", busy, 0);
        chk("t2_no_wr", fifo_wr, 0);

        // 3: back-pressure from fifo_full
        send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0); send(8'hB4, 0);
        fifo_full = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hC1;
        held = word(3, 0, 32'hB4B3B2B1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_in_ready_low", in_ready, 0);
            chk("t3_no_wr", fifo_wr, 0);
            chk("t3_held", fifo_wr_data, held);
            tick();
        end
        fifo_full = 1'b0;
        #1;
        chk("t3_release_wr", fifo_wr, 1);
        chk("t3_release_word", fifo_wr_data, held);
        send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 0);
        chk("t3_new_wr", fifo_wr, 1);
        chk("t3_new_word", fifo_wr_data, word(3, 0, 32'hC4C3C2C1));
        tick();

        // 4: single beat followed by idle time
        send(8'h5A, 0);
`ifdef NDS_ASYNC_FIFO_PACKER_TIMEOUT_EN
        k = 0;
        a = 1'b0;
        while (!a && k < 40) begin
            tick();
            k++;
            a = fifo_wr;
        end
        chk("t4_flush_cycles", 64'(k), 16);
        chk("t4_flush_word", fifo_wr_data, word(0, 0, 32'h0000005A));
        tick();
`else
        k = 0;
        repeat (20) begin
            tick();
            if (fifo_wr) k++;
        end
        chk("t4_no_push", 64'(k), 0);
        chk("t4_busy", busy, 1);
        send(8'h5B, 1);
        chk("t4_close_word", fifo_wr_data, word(1, 1, 32'h00005B5A));
        tick();
`endif
        repeat (3) tick();

        // 5: async reset mid-word drops the partial word
        send(8'hD1, 0); send(8'hD2, 0); send(8'hD3, 0);
        chk("t5_sb_empty", 64'(sb_q.size()), 0);
        #2 w_reset_n = 1'b0;
        m_acc = '0;
        m_idx = 0;
        m_idle = 0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_wr", fifo_wr, 0);
        chk("t5_rst_ready", in_ready, 1);
        @(negedge w_clk);
        #1 w_reset_n = 1'b1;
        tick();
        send(8'hE1, 0); send(8'hE2, 0); send(8'hE3, 0); send(8'hE4, 0);
        chk("t5_clean_wr", fifo_wr, 1);
        chk("t5_clean_word", fifo_wr_data, word(3, 0, 32'hE4E3E2E1));
        tick();

        // 6: random valid and full for 10k beats
        for (int i = 0; i < 10000; i++) begin
            while ($urandom_range(3) == 0) begin
                in_valid  = 1'b0;
                fifo_full = ($urandom_range(3) == 0);
                tick();
            end
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = ($urandom_range(7) == 0);
            k = 0;
            a = 1'b0;
            while (!a && k < 100) begin
                @(negedge w_clk);
                a = in_ready;
                tick();
                fifo_full = ($urandom_range(3) == 0);
                k++;
            end
            if (!a) chk("t6_accept_timeout", a, 1);
        end
        in_valid  = 1'b0;
        fifo_full = 1'b0;
        tick();
        send(8'h00, 1);
        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            tick();
            k++;
        end
        tick();
        chk("t6_drained", 64'(sb_q.size()), 0);
        chk("t6_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
